if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  reset; synchronous, active-high.
REQ-003 stall_i  input  1  back-end stall (ID/EX/MEM); IF/ID holds and PC holds while high.
REQ-004 branch_flag_i  input  1  branch taken, from ID branch_flag_o.
REQ-005 branch_addr_i  input  16  branch target, from ID branch_addr_o.
REQ-006 flush_i  input  1  pipeline flush (interrupt entry); overrides branch and stall.
REQ-007 flush_addr_i  input  16  fetch address after flush.
REQ-008 imem_req_o  output  1  instruction fetch request.
REQ-009 imem_addr_o  output  16  word address of the fetch.
REQ-010 imem_ack_i  input  1  fetch complete; imem_rdata_i valid in the same cycle.
REQ-011 imem_rdata_i  input  16  fetched instruction.
REQ-012 pc_o  output  16  IF/ID PC: address of the held instruction plus 1; feeds ID pc_i.
REQ-013 inst_o  output  16  IF/ID instruction; feeds ID inst_i.
REQ-014 stall_req_o  output  1  fetch-pending stall request to the stall controller.

Function
REQ-015 The block SHALL use three states: FETCH, SKID and DRAIN.
REQ-016 Handshake: once imem_req_o rises, imem_req_o and imem_addr_o SHALL hold stable through the ack cycle inclusive; imem_ack_i SHALL be ignored while imem_req_o is low.
REQ-017 FETCH: imem_req_o=1 and imem_addr_o=pc; a new request SHALL be issued back-to-back in the cycle after an ack.
REQ-018 FETCH with ack and stall_i=0: IF/ID SHALL load {pc+1, imem_rdata_i}; the next pc SHALL be branch_addr_i if branch_flag_i=1, else pc+1.
REQ-019 Branches SHALL have one delay slot: the instruction accepted in the cycle branch_flag_i is sampled high SHALL be kept.
REQ-020 branch_flag_i SHALL be sampled only in cycles where IF/ID advances.
REQ-021 FETCH with ack and stall_i=1: imem_rdata_i SHALL be captured in a skid register, IF/ID SHALL hold, and the state SHALL go to SKID.
REQ-022 SKID: imem_req_o=0; in the first cycle with stall_i=0, IF/ID SHALL load from the skid register, pc SHALL update per REQ-018, and the state SHALL return to FETCH.
REQ-023 stall_req_o SHALL equal (state==FETCH && imem_req_o && !imem_ack_i), combinationally.
REQ-024 While stall_req_o=1, IF/ID SHALL hold its contents regardless of stall_i.
REQ-025 flush_i=1 with no request outstanding:
- IF/ID SHALL load {flush_addr_i, 16'h0800 (NOP)};
- pc SHALL load flush_addr_i;
- any skid data SHALL be dropped;
- state SHALL go to FETCH.
REQ-026 flush_i=1 with a request outstanding and no ack: pc SHALL load flush_addr_i, IF/ID SHALL load NOP, and the state SHALL go to DRAIN.
REQ-027 DRAIN: request and address SHALL be held per REQ-016; the ack data SHALL be discarded; the state SHALL go to FETCH after the ack.
REQ-028 flush_i coinciding with an ack SHALL discard the acked data and go directly to FETCH at flush_addr_i.
REQ-029 Priority: rst > flush_i > stall_i > branch_flag_i.
REQ-030 PC arithmetic SHALL be 16-bit modulo; pc 0xFFFF SHALL increment to 0x0000.

Reset
REQ-031 While rst=1, the block SHALL set:
- pc=0x0000;
- pc_o=0x0000;
- inst_o=16'h0800;
- skid register cleared;
- state=FETCH;
- imem_req_o=0;
- stall_req_o=0.
REQ-032 The first request SHALL be issued to address 0x0000 in the first cycle after rst falls.
REQ-033 rst asserted mid-fetch SHALL abandon the outstanding request; the memory side SHALL be reset by the same rst.

Structure
REQ-034 The NOP encoding (16'h0800), the state encodings and the reset PC SHALL be defined in the shared defines.v.
REQ-035 The IF/ID register (pc_o, inst_o, hold, load, NOP-load) SHALL be a sub-module named if_id_reg.
REQ-036 The PC, skid register and state machine SHALL live in if_stage.

Verification
REQ-037 Zero-wait memory (ack every request cycle), words 0x4801, 0x4802, ...: inst_o follows one per cycle; pc_o=1,2,3...; stall_req_o never high.
REQ-038 Two-wait-state memory: stall_req_o high 2 cycles per fetch; IF/ID unchanged during the wait; addresses 0,1,2 fetched in order.
REQ-039 Branch_flag_i=1, target 0x0040, in the cycle the fetch at 0x0005 is acked: inst@0x0005 accepted as delay slot; next imem_addr_o=0x0040.
REQ-040 Ack with stall_i=1 for 3 cycles, then 0:
- SKID entered;
- imem_req_o=0 for those 3 cycles;
- skid word appears on inst_o the cycle after stall_i falls.
REQ-041 flush_i, flush_addr_i=0x0008, during a pending two-wait fetch:
- addr held until the ack;
- acked data discarded;
- inst_o=0x0800;
- next request to 0x0008.
REQ-042 rst pulsed mid-fetch at pc=0x0123: all outputs return to reset values; the first request after reset goes to 0x0000.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage: NOP encoding,
// reset PC, controller state encoding and the PC update rule.
package if_stage_pkg;

    localparam logic [15:0] NOP_INST = 16'h0800;
    localparam logic [15:0] RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_SKID  = 2'd1,
        ST_DRAIN = 2'd2
    } if_state_e;

    // Next fetch address once an instruction advances into IF/ID (16-bit wrap).
    function automatic logic [15:0] pc_next(input logic [15:0] pc,
                                            input logic        br,
                                            input logic [15:0] tgt);
        return br ? tgt : pc + 16'd1;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds {pc, inst} for the decode stage.
// A NOP load (flush) takes precedence over a normal load; otherwise it holds.
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        nop_load,
    input  logic [15:0] pc_d,
    input  logic [15:0] inst_d,
    output logic [15:0] pc_o,
    output logic [15:0] inst_o
);

    // Register update: reset to NOP, flush loads NOP at pc_d, load captures pc_d/inst_d
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_o   <= RESET_PC;
            inst_o <= NOP_INST;
        end else if (nop_load) begin
            pc_o   <= pc_d;
            inst_o <= NOP_INST;
        end else if (load) begin
            pc_o   <= pc_d;
            inst_o <= inst_d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, the skid register and the
// FETCH/SKID/DRAIN controller; the IF/ID register lives in if_id_reg.
//
// Memory handshake: imem_req_o and imem_addr_o rise together and stay stable
// up to and including the cycle imem_ack_i is high; imem_rdata_i is valid only
// in that ack cycle, and imem_ack_i carries no meaning while imem_req_o is low.
module if_stage
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [15:0] branch_addr_i,
    input  logic        flush_i,
    input  logic [15:0] flush_addr_i,
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [15:0] imem_rdata_i,
    output logic [15:0] pc_o,
    output logic [15:0] inst_o,
    output logic        stall_req_o,
    output if_state_e   state_o
);

    if_state_e   state;
    logic [15:0] pc;
    logic [15:0] skid;
    logic [15:0] drain_addr;
    logic        ack_v;
    logic        ifid_load;
    logic        ifid_nop;
    logic [15:0] ifid_pc_d;
    logic [15:0] ifid_inst_d;

    // DRAIN keeps presenting the abandoned address while pc already points at the flush target.
    assign imem_req_o  = !rst && (state == ST_FETCH || state == ST_DRAIN);
    assign imem_addr_o = (state == ST_DRAIN) ? drain_addr : pc;
    assign stall_req_o = (state == ST_FETCH) && imem_req_o && !imem_ack_i;
    assign ack_v       = imem_req_o && imem_ack_i;
    assign state_o     = state;

    // IF/ID load selection: flush forces a NOP, otherwise advance on an unstalled ack or skid release
    always_comb begin
        ifid_load   = 1'b0;
        ifid_nop    = flush_i;
        ifid_pc_d   = flush_i ? flush_addr_i : pc + 16'd1;
        ifid_inst_d = skid;
        if (!flush_i && !stall_i) begin
            case (state)
                ST_FETCH: begin
                    ifid_load   = ack_v;
                    ifid_inst_d = imem_rdata_i;
                end
                ST_SKID: ifid_load = 1'b1;
                default: ifid_load = 1'b0;
            endcase
        end
    end

    // Fetch controller: PC, skid capture and state, with flush overriding stall and branch
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            skid       <= 16'h0000;
            drain_addr <= RESET_PC;
        end else if (flush_i) begin
            pc   <= flush_addr_i;
            skid <= 16'h0000;
            // A request still waiting for its ack must be drained before refetching.
            if (state != ST_SKID && !ack_v) begin
                state <= ST_DRAIN;
                if (state == ST_FETCH) drain_addr <= pc;
            end else begin
                state <= ST_FETCH;
            end
        end else begin
            case (state)
                ST_FETCH: begin
                    if (ack_v) begin
                        if (stall_i) begin
                            skid  <= imem_rdata_i;
                            state <= ST_SKID;
                        end else begin
                            pc <= pc_next(pc, branch_flag_i, branch_addr_i);
                        end
                    end
                end
                ST_SKID: begin
                    if (!stall_i) begin
                        pc    <= pc_next(pc, branch_flag_i, branch_addr_i);
                        state <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (ack_v) state <= ST_FETCH;
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (ifid_load),
        .nop_load (ifid_nop),
        .pc_d     (ifid_pc_d),
        .inst_d   (ifid_inst_d),
        .pc_o     (pc_o),
        .inst_o   (inst_o)
    );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed per-cycle vector table, a mid-fetch reset
// sequence, then memory-model driven phases checked by a scoreboard.
`timescale 1ns/1ps
module tb_if_stage;
    import if_stage_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [15:0] branch_addr_i = 16'h0;
    logic        flush_i = 1'b0;
    logic [15:0] flush_addr_i = 16'h0;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic        imem_ack_i;
    logic [15:0] imem_rdata_i;
    logic [15:0] pc_o;
    logic [15:0] inst_o;
    logic        stall_req_o;
    if_state_e   state_o;

    always #5 clk = ~clk;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .branch_flag_i (branch_flag_i),
        .branch_addr_i (branch_addr_i),
        .flush_i       (flush_i),
        .flush_addr_i  (flush_addr_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .pc_o          (pc_o),
        .inst_o        (inst_o),
        .stall_req_o   (stall_req_o),
        .state_o       (state_o)
    );

    // ---------------- counters and check helper ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Memory contents: word at address a is a + 0x4801 (address 0 holds 0x4801).
    function automatic logic [15:0] memw(input logic [15:0] a);
        return a + 16'h4801;
    endfunction

    // ---------------- memory model / table-driven memory ----------------
    logic        mem_auto = 1'b0;
    logic        tbl_ack = 1'b0;
    logic [15:0] tbl_rdata = 16'h0;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'hDEAD;
    logic        mem_busy = 1'b0;
    int unsigned mem_left = 0;
    int unsigned wait_min = 0;
    int unsigned wait_max = 0;

    assign imem_ack_i   = mem_auto ? mem_ack   : tbl_ack;
    assign imem_rdata_i = mem_auto ? mem_rdata : tbl_rdata;

    always @(negedge clk) begin
        if (rst || !mem_auto) begin
            mem_busy = 1'b0;
            mem_ack  = 1'b0;
        end else begin
            if (mem_ack) mem_busy = 1'b0;
            mem_ack   = 1'b0;
            mem_rdata = 16'hDEAD;
            if (imem_req_o) begin
                if (!mem_busy) begin
                    mem_busy = 1'b1;
                    mem_left = $urandom_range(wait_max, wait_min);
                end
                if (mem_left == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = memw(imem_addr_o);
                end else begin
                    mem_left = mem_left - 1;
                end
            end
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        stall;
        logic        br;
        logic [15:0] baddr;
        logic        fl;
        logic [15:0] faddr;
        logic        ack;
        logic [15:0] rdata;
        logic        req;
        logic [15:0] addr;
        logic        sreq;
        logic [15:0] pc;
        logic [15:0] inst;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl[NV];

    function automatic vec_t mk(input logic s, input logic b, input logic [15:0] ba,
                                input logic f, input logic [15:0] fa, input logic a,
                                input logic [15:0] rd, input logic rq, input logic [15:0] ad,
                                input logic sr, input logic [15:0] p, input logic [15:0] in);
        vec_t v;
        v.stall = s; v.br = b; v.baddr = ba; v.fl = f; v.faddr = fa; v.ack = a; v.rdata = rd;
        v.req = rq; v.addr = ad; v.sreq = sr; v.pc = p; v.inst = in;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [15:0] m_addr;
    logic        cur_br;
    logic [15:0] cur_tgt;
    logic        flush_pend;
    logic [15:0] last_faddr;
    logic [31:0] prev_snap;
    logic        prev_req;
    logic        prev_ack;
    logic [15:0] prev_addr;

    task automatic pick_plan(input bit allow_br);
        cur_br  = allow_br && ($urandom_range(0, 4) == 0);
        cur_tgt = 16'($urandom_range(0, 65535));
        if (cur_tgt == m_addr) cur_tgt = cur_tgt + 16'd2;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] snap;
        logic [31:0] e;
        int          got_adv;
        int          cyc;
        int          target;
        int          budget;
        int          sr_cnt;
        int          b_adv;
        bit          adv;

        tbl[0]  = mk(0,0,16'h0000,0,16'h0000,0,16'h0000, 1,16'h0000,1,16'h0000,16'h0800);
        tbl[1]  = mk(0,0,16'h0000,0,16'h0000,1,16'h4801, 1,16'h0000,0,16'h0000,16'h0800);
        tbl[2]  = mk(0,0,16'h0000,0,16'h0000,1,16'h4802, 1,16'h0001,0,16'h0001,16'h4801);
        tbl[3]  = mk(1,0,16'h0000,0,16'h0000,1,16'h4803, 1,16'h0002,0,16'h0002,16'h4802);
        tbl[4]  = mk(1,0,16'h0000,0,16'h0000,0,16'h0000, 0,16'h0000,0,16'h0002,16'h4802);
        tbl[5]  = mk(1,0,16'h0000,0,16'h0000,1,16'hBAD1, 0,16'h0000,0,16'h0002,16'h4802);
        tbl[6]  = mk(0,0,16'h0000,0,16'h0000,0,16'h0000, 0,16'h0000,0,16'h0002,16'h4802);
        tbl[7]  = mk(0,1,16'h0099,0,16'h0000,0,16'h0000, 1,16'h0003,1,16'h0003,16'h4803);
        tbl[8]  = mk(1,1,16'h0099,0,16'h0000,0,16'h0000, 1,16'h0003,1,16'h0003,16'h4803);
        tbl[9]  = mk(0,1,16'h0040,0,16'h0000,1,16'h4804, 1,16'h0003,0,16'h0003,16'h4803);
        tbl[10] = mk(0,0,16'h0000,0,16'h0000,0,16'h0000, 1,16'h0040,1,16'h0004,16'h4804);
        tbl[11] = mk(0,0,16'h0000,1,16'h0008,0,16'h0000, 1,16'h0040,1,16'h0004,16'h4804);
        tbl[12] = mk(0,0,16'h0000,0,16'h0000,0,16'h0000, 1,16'h0040,0,16'h0008,16'h0800);
        tbl[13] = mk(0,0,16'h0000,0,16'h0000,1,16'h4841, 1,16'h0040,0,16'h0008,16'h0800);
        tbl[14] = mk(0,1,16'h0077,0,16'h0000,0,16'h0000, 1,16'h0008,1,16'h0008,16'h0800);
        tbl[15] = mk(0,0,16'h0000,1,16'h0020,1,16'h4809, 1,16'h0008,0,16'h0008,16'h0800);
        tbl[16] = mk(0,0,16'h0000,0,16'h0000,1,16'h4821, 1,16'h0020,0,16'h0020,16'h0800);
        tbl[17] = mk(1,0,16'h0000,0,16'h0000,1,16'h4822, 1,16'h0021,0,16'h0021,16'h4821);
        tbl[18] = mk(1,0,16'h0000,1,16'h0030,0,16'h0000, 0,16'h0000,0,16'h0021,16'h4821);
        tbl[19] = mk(0,1,16'h0055,0,16'h0000,0,16'h0000, 1,16'h0030,1,16'h0030,16'h0800);
        tbl[20] = mk(0,1,16'hFFFF,0,16'h0000,1,16'h4831, 1,16'h0030,0,16'h0030,16'h0800);
        tbl[21] = mk(0,0,16'h0000,0,16'h0000,1,16'hABCD, 1,16'hFFFF,0,16'h0031,16'h4831);
        tbl[22] = mk(0,1,16'h0099,0,16'h0000,0,16'h0000, 1,16'h0000,1,16'h0000,16'hABCD);
        tbl[23] = mk(0,0,16'h0000,0,16'h0000,1,16'h4801, 1,16'h0000,0,16'h0000,16'hABCD);
        tbl[24] = mk(0,0,16'h0000,0,16'h0000,0,16'h0000, 1,16'h0001,1,16'h0001,16'h4801);

        // ---- power-on reset ----
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        check("rst_req", imem_req_o, 1'b0);
        check("rst_sreq", stall_req_o, 1'b0);
        check("rst_pc", pc_o, 16'h0000);
        check("rst_inst", inst_o, 16'h0800);
        check("rst_state", state_o, ST_FETCH);

        // ---- directed table ----
        for (int i = 0; i < NV; i++) begin
            @(negedge clk); #1;
            if (i == 0) rst = 1'b0;
            stall_i       = tbl[i].stall;
            branch_flag_i = tbl[i].br;
            branch_addr_i = tbl[i].baddr;
            flush_i       = tbl[i].fl;
            flush_addr_i  = tbl[i].faddr;
            tbl_ack       = tbl[i].ack;
            tbl_rdata     = tbl[i].rdata;
            #1;
            check($sformatf("v%0d_req", i), imem_req_o, tbl[i].req);
            if (tbl[i].req) check($sformatf("v%0d_addr", i), imem_addr_o, tbl[i].addr);
            check($sformatf("v%0d_sreq", i), stall_req_o, tbl[i].sreq);
            check($sformatf("v%0d_pc", i), pc_o, tbl[i].pc);
            check($sformatf("v%0d_inst", i), inst_o, tbl[i].inst);
        end

        // ---- reset pulsed in the middle of a fetch at 0x0123 ----
        @(negedge clk); #1;
        stall_i = 1'b0; branch_flag_i = 1'b0;
        flush_i = 1'b1; flush_addr_i = 16'h0123;
        tbl_ack = 1'b1; tbl_rdata = 16'hBEEF;
        @(negedge clk); #1;
        flush_i = 1'b0; tbl_ack = 1'b0;
        #1;
        check("mid_req", imem_req_o, 1'b1);
        check("mid_addr", imem_addr_o, 16'h0123);
        check("mid_sreq", stall_req_o, 1'b1);
        check("mid_pc", pc_o, 16'h0123);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst2_req_now", imem_req_o, 1'b0);
        check("rst2_sreq_now", stall_req_o, 1'b0);
        @(negedge clk); #1;
        mem_auto = 1'b1; wait_min = 0; wait_max = 0;
        check("rst2_pc", pc_o, 16'h0000);
        check("rst2_inst", inst_o, 16'h0800);
        check("rst2_state", state_o, ST_FETCH);
        check("rst2_req", imem_req_o, 1'b0);
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        check("post_rst_req", imem_req_o, 1'b1);
        check("post_rst_addr", imem_addr_o, 16'h0000);

        // ---- memory-model phases: 0 zero-wait, 1 two-wait, 2 random ----
        m_addr     = 16'h0000;
        flush_pend = 1'b0;
        last_faddr = 16'hFFFF;
        exp_q.delete();
        exp_q.push_back({m_addr + 16'd1, memw(m_addr)});
        pick_plan(1'b0);
        prev_snap = {pc_o, inst_o};
        prev_req  = imem_req_o;
        prev_ack  = imem_ack_i;
        prev_addr = imem_addr_o;
        sr_cnt    = 0;

        for (int p = 0; p < 3; p++) begin
            case (p)
                0: begin wait_min = 0; wait_max = 0; target = 16;  budget = 40;   end
                1: begin wait_min = 2; wait_max = 2; target = 8;   budget = 100;  end
                default: begin wait_min = 0; wait_max = 3; target = 150; budget = 3000; end
            endcase
            got_adv = 0; cyc = 0; b_adv = 0;
            while (got_adv < target && cyc < budget) begin
                @(negedge clk); #2;
                cyc++;
                if (prev_req && !prev_ack) begin
                    check("hold_req", imem_req_o, 1'b1);
                    check("hold_addr", imem_addr_o, prev_addr);
                end
                if (!imem_req_o) check("sreq_idle", stall_req_o, 1'b0);
                if (p == 0) check("sreq_zero_wait", stall_req_o, 1'b0);

                snap = {pc_o, inst_o};
                adv  = (snap != prev_snap);
                if (p == 0 && cyc >= 2) check("one_per_cycle", adv, 1'b1);
                if (adv) begin
                    if (exp_q.size() == 0) begin
                        check("ifid_unexpected", snap, 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        check("ifid", snap, e);
                    end
                    if (p == 1) begin
                        b_adv++;
                        if (b_adv > 2) check("two_wait_cycles", sr_cnt, 2);
                    end
                    sr_cnt = 0;
                    if (flush_pend) begin
                        flush_pend = 1'b0;
                    end else begin
                        m_addr = cur_br ? cur_tgt : m_addr + 16'd1;
                        exp_q.push_back({m_addr + 16'd1, memw(m_addr)});
                    end
                    pick_plan(p == 2);
                    got_adv++;
                    prev_snap = snap;
                end
                if (stall_req_o) sr_cnt++;

                prev_req  = imem_req_o;
                prev_ack  = imem_ack_i;
                prev_addr = imem_addr_o;

                if (p == 2) begin
                    stall_i = ($urandom_range(0, 3) == 0);
                    flush_i = ($urandom_range(0, 24) == 0);
                    if (flush_i) begin
                        flush_addr_i = 16'($urandom_range(0, 4095));
                        if (flush_addr_i == last_faddr) flush_addr_i = flush_addr_i + 16'd1;
                        last_faddr = flush_addr_i;
                        m_addr     = flush_addr_i;
                        exp_q.delete();
                        exp_q.push_back({flush_addr_i, 16'h0800});
                        exp_q.push_back({m_addr + 16'd1, memw(m_addr)});
                        flush_pend = 1'b1;
                        pick_plan(1'b1);
                    end
                end else begin
                    stall_i = 1'b0;
                    flush_i = 1'b0;
                end
                branch_flag_i = cur_br;
                branch_addr_i = cur_tgt;
            end
            check($sformatf("progress_phase%0d", p), (got_adv >= target), 1'b1);
        end

        stall_i = 1'b0; flush_i = 1'b0; branch_flag_i = 1'b0;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
